// File: rtl/cache_controller_pkg.sv
// Shared types, widths and block-word helpers for the direct-mapped cache controller.
package cache_controller_pkg;

    localparam int ADDR_W          = 10;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFF_W           = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        ALLOCATE   = 2'd2,
        WRITE_THRU = 2'd3
    } state_t;

    // Word offset 0 sits in the most significant slot of a memory block.
    function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                     input logic [OFF_W-1:0]   off);
        logic [WORD_W-1:0] w;
        case (off)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            2'd3:    w = blk[31:0];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

    // Return blk with the word at offset off replaced by word.
    function automatic logic [BLOCK_W-1:0] block_put(input logic [BLOCK_W-1:0] blk,
                                                     input logic [OFF_W-1:0]   off,
                                                     input logic [WORD_W-1:0]  word);
        logic [BLOCK_W-1:0] res;
        res = blk;
        case (off)
            2'd0:    res[127:96] = word;
            2'd1:    res[95:64]  = word;
            2'd2:    res[63:32]  = word;
            2'd3:    res[31:0]   = word;
            default: res[31:0]   = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cache_controller_line_array.sv
// Line storage: valid/tag/block per line, synchronous write, combinational read by index.
module cache_line_array
    import cache_controller_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = 2,
    parameter int TAG_W     = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX_W-1:0]   rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_block,
    input  logic               wr_block_en,
    input  logic               wr_word_en,
    input  logic [IDX_W-1:0]   wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_block,
    input  logic [OFF_W-1:0]   wr_offset,
    input  logic [WORD_W-1:0]  wr_word
);

    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]     tag_r  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_r [NUM_LINES];

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_r[rd_index];
    assign rd_block = data_r[rd_index];

    // Valid bits: cleared by reset, set when a whole block is filled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= {NUM_LINES{1'b0}};
        end else if (wr_block_en) begin
            valid_r[wr_index] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data: full-block fill on allocate, single-word update on write hit.
    always_ff @(posedge clk) begin
        if (wr_block_en) begin
            tag_r[wr_index]  <= wr_tag;
            data_r[wr_index] <= wr_block;
        end else if (wr_word_en) begin
            data_r[wr_index] <= block_put(data_r[wr_index], wr_offset, wr_word);
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller with a fixed-latency memory port.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int MEM_WAIT  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_read,
    input  logic               cpu_write,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [WORD_W-1:0]  cpu_wdata,
    output logic [WORD_W-1:0]  cpu_rdata,
    output logic               cpu_ready,
    output logic               cpu_done,
    output logic               mem_read,
    output logic               mem_lock,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata
);

    localparam int          IDX_W     = $clog2(NUM_LINES);
    localparam int          TAG_W     = ADDR_W - OFF_W - IDX_W;
    localparam logic [3:0]  WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t              state_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [WORD_W-1:0]   wdata_r;
    logic                write_r;
    logic [3:0]          cnt_r;
    logic [WORD_W-1:0]   cpu_rdata_r;
    logic                cpu_ready_r;
    logic                cpu_done_r;
    logic                mem_read_r;
    logic                mem_lock_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [BLOCK_W-1:0]  mem_wdata_r;

    logic [OFF_W-1:0]    off_s;
    logic [IDX_W-1:0]    idx_s;
    logic [TAG_W-1:0]    tag_s;
    logic                line_valid_s;
    logic [TAG_W-1:0]    line_tag_s;
    logic [BLOCK_W-1:0]  line_block_s;
    logic                hit_s;
    logic                fill_en_s;
    logic                word_en_s;

    assign off_s = addr_r[OFF_W-1:0];
    assign idx_s = addr_r[OFF_W +: IDX_W];
    assign tag_s = addr_r[ADDR_W-1 -: TAG_W];
    assign hit_s = line_valid_s && (line_tag_s == tag_s);

    // Line writes are gated by rst_n so a reset on the last ALLOCATE edge leaves the line untouched.
    assign fill_en_s = rst_n && (state_r == ALLOCATE) && (cnt_r == 4'd0);
    assign word_en_s = rst_n && (state_r == COMPARE) && write_r && hit_s;

    cache_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_index    (idx_s),
        .rd_valid    (line_valid_s),
        .rd_tag      (line_tag_s),
        .rd_block    (line_block_s),
        .wr_block_en (fill_en_s),
        .wr_word_en  (word_en_s),
        .wr_index    (idx_s),
        .wr_tag      (tag_s),
        .wr_block    (mem_rdata),
        .wr_offset   (off_s),
        .wr_word     (wdata_r)
    );

    assign cpu_rdata = cpu_rdata_r;
    assign cpu_ready = cpu_ready_r;
    assign cpu_done  = cpu_done_r;
    assign mem_read  = mem_read_r;
    assign mem_lock  = mem_lock_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

    // Controller FSM; every output is registered and set on the edge that enters the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {WORD_W{1'b0}};
            write_r     <= 1'b0;
            cnt_r       <= 4'd0;
            cpu_rdata_r <= {WORD_W{1'b0}};
            cpu_ready_r <= 1'b1;
            cpu_done_r  <= 1'b0;
            mem_read_r  <= 1'b1;
            mem_lock_r  <= 1'b1;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {BLOCK_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    cpu_done_r <= 1'b0;
                    if (cpu_read || cpu_write) begin
                        addr_r      <= cpu_addr;
                        wdata_r     <= cpu_wdata;
                        write_r     <= cpu_write;
                        cpu_ready_r <= 1'b0;
                        state_r     <= COMPARE;
                    end else begin
                        cpu_ready_r <= 1'b1;
                    end
                end
                COMPARE: begin
                    if (!write_r && hit_s) begin
                        cpu_rdata_r <= block_word(line_block_s, off_s);
                        cpu_done_r  <= 1'b1;
                        cpu_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end else if (!write_r) begin
                        cnt_r       <= WAIT_LOAD;
                        mem_lock_r  <= 1'b0;
                        mem_read_r  <= 1'b1;
                        mem_addr_r  <= {tag_s, idx_s, 2'b00};
                        state_r     <= ALLOCATE;
                    end else begin
                        // Write hit already updated the line this edge; miss leaves it alone.
                        cnt_r       <= WAIT_LOAD;
                        mem_lock_r  <= 1'b0;
                        mem_read_r  <= 1'b0;
                        mem_addr_r  <= addr_r;
                        mem_wdata_r <= {96'd0, wdata_r};
                        cpu_done_r  <= (WAIT_LOAD == 4'd0);
                        state_r     <= WRITE_THRU;
                    end
                end
                ALLOCATE: begin
                    if (cnt_r == 4'd0) begin
                        mem_lock_r <= 1'b1;
                        mem_read_r <= 1'b1;
                        mem_addr_r <= {ADDR_W{1'b0}};
                        state_r    <= COMPARE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                WRITE_THRU: begin
                    if (cnt_r == 4'd0) begin
                        cpu_done_r  <= 1'b0;
                        cpu_ready_r <= 1'b1;
                        mem_lock_r  <= 1'b1;
                        mem_read_r  <= 1'b1;
                        mem_addr_r  <= {ADDR_W{1'b0}};
                        mem_wdata_r <= {BLOCK_W{1'b0}};
                        state_r     <= IDLE;
                    end else begin
                        // Raise done so it is visible during the final memory cycle.
                        cnt_r      <= cnt_r - 4'd1;
                        cpu_done_r <= (cnt_r == 4'd1);
                    end
                end
                default: begin
                    cpu_done_r  <= 1'b0;
                    cpu_ready_r <= 1'b1;
                    mem_lock_r  <= 1'b1;
                    mem_read_r  <= 1'b1;
                    mem_addr_r  <= {ADDR_W{1'b0}};
                    mem_wdata_r <= {BLOCK_W{1'b0}};
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller (NUM_LINES=4, MEM_WAIT=2) with a word-addressed memory model.
module tb_cache_controller;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_read, cpu_write;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata, cpu_rdata;
    logic         cpu_ready, cpu_done;
    logic         mem_read, mem_lock;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    logic [31:0]  mem [1024];
    logic         mem_init;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    cache_controller #(.NUM_LINES(4), .MEM_WAIT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_done  (cpu_done),
        .mem_read  (mem_read),
        .mem_lock  (mem_lock),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Block read: offset 0 in the top word.
    assign mem_rdata = {mem[{mem_addr[9:2], 2'b00}], mem[{mem_addr[9:2], 2'b01}],
                        mem[{mem_addr[9:2], 2'b10}], mem[{mem_addr[9:2], 2'b11}]};

    // Memory model: preload contents, then absorb write-through cycles.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[0]   <= 32'h0000_3CC3;
            mem[2]   <= 32'h0000_1234;
            mem[3]   <= 32'h0000_5A5A;
            mem[32]  <= 32'h0000_4242;
            mem[256] <= 32'h0000_7777;
            mem[512] <= 32'h0000_0CCC;
            mem[768] <= 32'h0000_00C3;
        end else if (!mem_lock && !mem_read) begin
            mem[mem_addr] <= mem_wdata[31:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU transaction; latency counts rising edges from the one that samples the request.
    task automatic txn(input string tag, input logic rd, input logic wr, input logic [9:0] addr,
                       input logic [31:0] wd, input logic noise,
                       input int exp_lat, input logic [31:0] exp_rdata, input int exp_lock,
                       input logic [9:0] exp_maddr, input logic exp_mread, input logic [31:0] exp_mwd);
        int          lat;
        int          lock_n;
        logic        done_seen;
        logic        upper;
        logic [31:0] rdata;
        logic [9:0]  maddr;
        logic        mread;
        logic [31:0] mwd;
        lock_n = 0; done_seen = 1'b0; upper = 1'b0;
        rdata = 32'h0; maddr = 10'h0; mread = 1'b1; mwd = 32'h0;
        @(negedge clk);
        cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        if (noise) begin
            cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 10'h004;
        end else begin
            cpu_read = 1'b0; cpu_write = 1'b0;
        end
        while (!done_seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!mem_lock) begin
                lock_n++; maddr = mem_addr; mread = mem_read; mwd = mem_wdata[31:0];
            end
            upper = upper | (|mem_wdata[127:32]);
            if (cpu_done) begin
                done_seen = 1'b1; rdata = cpu_rdata;
            end
        end
        cpu_read = 1'b0; cpu_write = 1'b0;
        check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        check({tag, "_latency"},   32'(lat), 32'(exp_lat));
        check({tag, "_rdata"},     rdata, exp_rdata);
        check({tag, "_lock_cycles"}, 32'(lock_n), 32'(exp_lock));
        check({tag, "_mem_addr"},  32'(maddr), 32'(exp_maddr));
        check({tag, "_mem_read"},  32'(mread), 32'(exp_mread));
        check({tag, "_mem_wdata"}, mwd, exp_mwd);
        check({tag, "_wdata_hi"},  32'(upper), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(cpu_done), 32'd0);
        check({tag, "_ready_after"}, 32'(cpu_ready), 32'd1);
    endtask

    initial begin
        logic seen_done;
        rst_n = 1'b0; mem_init = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = 10'h0; cpu_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  32'(cpu_ready), 32'd1);
        check("rst_done",   32'(cpu_done), 32'd0);
        check("rst_lock",   32'(mem_lock), 32'd1);
        check("rst_mread",  32'(mem_read), 32'd1);
        check("rst_maddr",  32'(mem_addr), 32'd0);
        check("rst_rdata",  cpu_rdata, 32'd0);
        check("rst_wdata",  32'(|mem_wdata), 32'd0);
        rst_n = 1'b1; mem_init = 1'b0;

        //   tag           rd    wr    addr    wdata   noise lat rdata        lock maddr  mrd   mwd
        txn("rd0_miss",   1'b1, 1'b0, 10'h000, 32'h0, 1'b0, 5, 32'h3CC3, 2, 10'h000, 1'b1, 32'h0);
        txn("rd0_hit",    1'b1, 1'b0, 10'h000, 32'h0, 1'b0, 2, 32'h3CC3, 0, 10'h000, 1'b1, 32'h0);
        txn("rd2_hit",    1'b1, 1'b0, 10'h002, 32'h0, 1'b0, 2, 32'h1234, 0, 10'h000, 1'b1, 32'h0);
        txn("wr1_hit",    1'b0, 1'b1, 10'h001, 32'hAAAA, 1'b0, 3, 32'h1234, 2, 10'h001, 1'b0, 32'hAAAA);
        txn("rd1_hit",    1'b1, 1'b0, 10'h001, 32'h0, 1'b0, 2, 32'hAAAA, 0, 10'h000, 1'b1, 32'h0);
        txn("rd200_miss", 1'b1, 1'b0, 10'h200, 32'h0, 1'b0, 5, 32'h0CCC, 2, 10'h200, 1'b1, 32'h0);
        txn("rd300_evict",1'b1, 1'b0, 10'h300, 32'h0, 1'b0, 5, 32'h00C3, 2, 10'h300, 1'b1, 32'h0);
        txn("rd200_again",1'b1, 1'b0, 10'h200, 32'h0, 1'b0, 5, 32'h0CCC, 2, 10'h200, 1'b1, 32'h0);
        txn("both_wr010", 1'b1, 1'b1, 10'h010, 32'h55, 1'b0, 3, 32'h0CCC, 2, 10'h010, 1'b0, 32'h55);
        txn("rd200_kept", 1'b1, 1'b0, 10'h200, 32'h0, 1'b0, 2, 32'h0CCC, 0, 10'h000, 1'b1, 32'h0);
        txn("rd010_miss", 1'b1, 1'b0, 10'h010, 32'h0, 1'b0, 5, 32'h0055, 2, 10'h010, 1'b1, 32'h0);
        txn("rd100_noise",1'b1, 1'b0, 10'h100, 32'h0, 1'b1, 5, 32'h7777, 2, 10'h100, 1'b1, 32'h0);

        // Reset during the second ALLOCATE cycle of a read of 0x020.
        seen_done = 1'b0;
        @(negedge clk);
        cpu_read = 1'b1; cpu_addr = 10'h020;
        @(posedge clk);
        @(negedge clk);
        cpu_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_alloc_lock", 32'(mem_lock), 32'd0);
        @(posedge clk);
        @(negedge clk);
        seen_done = seen_done | cpu_done;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        seen_done = seen_done | cpu_done;
        check("abort_lock",  32'(mem_lock), 32'd1);
        check("abort_ready", 32'(cpu_ready), 32'd1);
        check("abort_maddr", 32'(mem_addr), 32'd0);
        check("abort_done",  32'(seen_done), 32'd0);
        rst_n = 1'b1;
        txn("rd020_after",1'b1, 1'b0, 10'h020, 32'h0, 1'b0, 5, 32'h4242, 2, 10'h020, 1'b1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
